// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, issues one instruction-memory request at a
// time, buffers the returned word and hands it to decode over valid/ready.
// Redirects (jump > branch) are honoured in every state. A response that is
// already in flight when a redirect arrives is drained and discarded.
// Optional macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect target parks
// the fetcher in FAULT. Without the macro, target bits [1:0] are cleared.
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    output logic [31:0] pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_HOLD
`ifdef FETCH_MISALIGN_TRAP_EN
        , S_FAULT
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic [31:0] instr_q, ipc_q;
    logic        capture;

    logic        redirect;
    logic [31:0] raw_tgt, tgt;
    logic        tgt_bad;
    state_t      redir_st;  // where a redirect sends us when nothing must drain
    state_t      drain_st;  // where we go once a dropped response has arrived

    assign redirect = jump | branch_taken;
    assign raw_tgt  = jump ? jump_target : branch_target;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic [31:0] fault_pc_q, fault_pc_d;
    assign tgt      = raw_tgt;
    assign tgt_bad  = redirect && (raw_tgt[1:0] != 2'b00);
    assign redir_st = tgt_bad ? S_FAULT : S_REQ;
    // pc only becomes misaligned through a misaligned redirect, so a drain
    // that ends with a misaligned pc owes us a trip into FAULT
    assign drain_st = (pc_q[1:0] != 2'b00) ? S_FAULT : S_REQ;
`else
    assign tgt      = {raw_tgt[31:2], 2'b00};
    assign tgt_bad  = 1'b0;
    assign redir_st = S_REQ;
    assign drain_st = S_REQ;
`endif

    // Next-state, next-pc and drop-flag logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        capture = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_pc_d = fault_pc_q;
        if (tgt_bad) fault_pc_d = raw_tgt;
`endif
        case (state_q)
            S_IDLE: state_d = redirect ? redir_st : S_REQ;
            S_REQ: begin
                if (imem_gnt) begin
                    state_d = S_WAIT;
                    drop_d  = redirect;
                end else if (redirect) begin
                    // withdraw the request for one cycle, re-issue via IDLE
                    state_d = (redir_st == S_REQ) ? S_IDLE : redir_st;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    drop_d = 1'b0;
                    if (redirect)    state_d = redir_st;
                    else if (drop_q) state_d = drain_st;
                    else begin
                        capture = 1'b1;
                        state_d = S_HOLD;
                    end
                end else if (redirect) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect) state_d = redir_st;
                else if (if_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            S_FAULT: if (redirect) state_d = redir_st;
`endif
            default: state_d = S_IDLE;
        endcase
        // a redirect always wins over the sequential pc+4
        if (redirect) pc_d = tgt;
    end

    // State, pc and drop flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_VECTOR;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    // Decode buffer: loaded only from a response that was not squashed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= 32'h0;
            ipc_q   <= RESET_VECTOR;
        end else if (capture) begin
            instr_q <= imem_rdata;
            ipc_q   <= pc_q;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Offending target of the most recent misaligned redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fault_pc_q <= 32'h0;
        else        fault_pc_q <= fault_pc_d;
    end

    assign fetch_fault = (state_q == S_FAULT);
    assign fault_pc    = fault_pc_q;
`endif

    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = pc_q;
    assign if_valid  = (state_q == S_HOLD);
    assign if_instr  = instr_q;
    assign if_pc     = ipc_q;
    assign pc        = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized run
// checked against an architectural pc model and a memory responder.
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        jump, branch_taken, if_ready;
    logic [31:0] jump_target, branch_target;
    logic        imem_req, imem_gnt, imem_rvalid, if_valid;
    logic [31:0] imem_addr, imem_rdata, if_instr, if_pc, pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_fault;
    logic [31:0] fault_pc;
`endif

    fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .jump(jump), .jump_target(jump_target),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_ready(if_ready), .pc(pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        , .fetch_fault(fetch_fault), .fault_pc(fault_pc)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // memory responder knobs and state
    int          gnt_pct = 100;
    int          rv_dly_max = 1;
    bit          rv_en = 1'b1;
    bit          use_bad = 1'b0;
    bit          force_stale = 1'b0;
    bit          outst = 1'b0;
    logic [31:0] oaddr = 32'h0;
    int          rem = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    // one clock: advance, then service the memory model and drive inputs
    task automatic tick();
        logic        granted, delivered;
        logic [31:0] gaddr;
        granted   = imem_req && imem_gnt;
        delivered = imem_rvalid && !force_stale;
        gaddr     = imem_addr;
        @(posedge clk); #1;
        if (delivered || !rst_n) outst = 1'b0;
        if (granted && rst_n) begin
            outst = 1'b1;
            oaddr = gaddr;
            rem   = $urandom_range(rv_dly_max - 1, 0);
        end else if (outst && rem > 0) rem--;
        imem_rvalid = force_stale || (outst && rem == 0 && rv_en);
        imem_rdata  = force_stale ? 32'hBAD0_BAD0 :
                      use_bad     ? 32'hDEAD_BEEF :
                      imem_rvalid ? word_of(oaddr) : $urandom;
        imem_gnt    = ($urandom_range(99, 0) < gnt_pct);
    endtask

    // tick until a condition holds: 0=imem_req, 1=if_valid, 2=fetch_fault
    task automatic wait_for(input int what, output bit ok);
        bit hit;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            hit = (what == 0) ? imem_req : if_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (what == 2) hit = fetch_fault;
`endif
            if (hit) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_cmp++; if (pc !== 32'h0)        begin n_err++; $display("FAIL rst_pc got %h want 0", pc); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr got %h want 0", imem_addr); end
        n_cmp++; if (if_pc !== 32'h0)     begin n_err++; $display("FAIL rst_if_pc got %h want 0", if_pc); end
        n_cmp++; if (if_instr !== 32'h0)  begin n_err++; $display("FAIL rst_if_instr got %h want 0", if_instr); end
        n_cmp++; if (imem_req !== 1'b0)   begin n_err++; $display("FAIL rst_req got %b want 0", imem_req); end
        n_cmp++; if (if_valid !== 1'b0)   begin n_err++; $display("FAIL rst_valid got %b want 0", if_valid); end
`ifdef FETCH_MISALIGN_TRAP_EN
        n_cmp++; if (fetch_fault !== 1'b0 || fault_pc !== 32'h0) begin n_err++; $display("FAIL rst_fault got %b/%h want 0/0", fetch_fault, fault_pc); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_sequential();
        logic [31:0] reqs[$], pcs[$], ins[$];
        int          acc[$];
        gnt_pct = 100; rv_dly_max = 1; if_ready = 1'b1;
        rst_n = 1'b1;
        for (int c = 0; c < 40 && (reqs.size() < 3 || pcs.size() < 2); c++) begin
            tick();
            if (imem_req) reqs.push_back(imem_addr);
            if (if_valid && if_ready) begin
                pcs.push_back(if_pc); ins.push_back(if_instr); acc.push_back(c);
            end
        end
        n_cmp++;
        if (reqs.size() < 3 || pcs.size() < 2) begin
            n_err++; $display("FAIL seq_timeout got %0d reqs/%0d accepts want 3/2", reqs.size(), pcs.size());
        end else begin
            n_cmp++; if (reqs[0] !== 32'h0 || reqs[1] !== 32'h4 || reqs[2] !== 32'h8) begin
                n_err++; $display("FAIL seq_addr got %h,%h,%h want 0,4,8", reqs[0], reqs[1], reqs[2]); end
            n_cmp++; if (pcs[0] !== 32'h0 || pcs[1] !== 32'h4) begin
                n_err++; $display("FAIL seq_if_pc got %h,%h want 0,4", pcs[0], pcs[1]); end
            n_cmp++; if (ins[0] !== 32'h0000_0013) begin
                n_err++; $display("FAIL seq_instr got %h want 00000013", ins[0]); end
            n_cmp++; if (acc[1] - acc[0] !== 3) begin
                n_err++; $display("FAIL seq_rate got %0d want 3 cycles", acc[1] - acc[0]); end
        end
        if_ready = 1'b0;
    endtask

    task automatic test_hold_stall();
        bit          ok;
        logic [31:0] i0, p0, c0;
        if_ready = 1'b0;
        wait_for(1, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL hold_timeout got no if_valid want if_valid"); end
        i0 = if_instr; p0 = if_pc; c0 = pc;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if (if_valid !== 1'b1 || if_instr !== i0 || if_pc !== p0 || imem_req !== 1'b0 || pc !== c0) begin
                n_err++; $display("FAIL hold_stable got v=%b i=%h p=%h req=%b pc=%h want v=1 i=%h p=%h req=0 pc=%h",
                                  if_valid, if_instr, if_pc, imem_req, pc, i0, p0, c0);
            end
        end
        if_ready = 1'b1;
        tick();
        n_cmp++; if (pc !== c0 + 32'd4 || if_valid !== 1'b0) begin
            n_err++; $display("FAIL hold_accept got pc=%h v=%b want pc=%h v=0", pc, if_valid, c0 + 32'd4); end
    endtask

    task automatic test_squash();
        bit          ok, seen;
        logic [31:0] first;
        if_ready = 1'b1; gnt_pct = 100; rv_en = 1'b0;
        wait_for(0, ok);
        tick();
        n_cmp++; if (!ok || imem_req !== 1'b0) begin n_err++; $display("FAIL squash_setup got ok=%b req=%b want 1/0", ok, imem_req); end
        branch_taken = 1'b1; branch_target = 32'h100;
        tick();
        branch_taken = 1'b0;
        rv_en = 1'b1; use_bad = 1'b1;
        tick();
        use_bad = 1'b0;
        seen = 1'b0; first = 32'hx;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (imem_req && !seen) begin first = imem_addr; seen = 1'b1; end
            if (if_valid) break;
        end
        n_cmp++; if (first !== 32'h100) begin n_err++; $display("FAIL squash_addr got %h want 00000100", first); end
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin
            n_err++; $display("FAIL squash_if_pc got v=%b %h want v=1 00000100", if_valid, if_pc); end
        n_cmp++; if (if_instr !== word_of(32'h100)) begin
            n_err++; $display("FAIL squash_word got %h want %h", if_instr, word_of(32'h100)); end
    endtask

    task automatic test_priority();
        bit ok;
        if_ready = 1'b0;
        wait_for(1, ok);
        if_ready = 1'b1;
        jump = 1'b1; jump_target = 32'h200; branch_taken = 1'b1; branch_target = 32'h300;
        tick();
        jump = 1'b0; branch_taken = 1'b0;
        n_cmp++; if (!ok || pc !== 32'h200 || if_valid !== 1'b0) begin
            n_err++; $display("FAIL prio_pc got ok=%b pc=%h v=%b want 1/00000200/0", ok, pc, if_valid); end
        wait_for(0, ok);
        n_cmp++; if (!ok || imem_addr !== 32'h200) begin
            n_err++; $display("FAIL prio_addr got %h want 00000200", imem_addr); end
    endtask

    task automatic test_wrap();
        bit ok;
        if_ready = 1'b1;
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        tick();
        jump = 1'b0;
        n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_jump got %h want fffffffc", pc); end
        wait_for(1, ok);
        n_cmp++; if (!ok || if_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_if_pc got %h want fffffffc", if_pc); end
        tick();
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL wrap_pc got %h want 0", pc); end
        wait_for(0, ok);
        n_cmp++; if (!ok || imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr got %h want 0", imem_addr); end
    endtask

`ifdef FETCH_MISALIGN_TRAP_EN
    task automatic test_fault();
        bit ok;
        jump = 1'b1; jump_target = 32'h102;
        tick();
        jump = 1'b0;
        wait_for(2, ok);
        n_cmp++; if (!ok || fault_pc !== 32'h102) begin n_err++; $display("FAIL fault_enter got ok=%b fpc=%h want 1/00000102", ok, fault_pc); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0) begin
                n_err++; $display("FAIL fault_park got f=%b req=%b v=%b want 1/0/0", fetch_fault, imem_req, if_valid); end
        end
        jump = 1'b1; jump_target = 32'h104;
        tick();
        jump = 1'b0;
        n_cmp++; if (fetch_fault !== 1'b0) begin n_err++; $display("FAIL fault_exit got %b want 0", fetch_fault); end
        wait_for(0, ok);
        n_cmp++; if (!ok || imem_addr !== 32'h104) begin n_err++; $display("FAIL fault_addr got %h want 00000104", imem_addr); end
    endtask
`else
    task automatic test_align();
        bit ok;
        jump = 1'b1; jump_target = 32'h102;
        tick();
        jump = 1'b0;
        n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL align_pc got %h want 00000100", pc); end
        wait_for(0, ok);
        n_cmp++; if (!ok || imem_addr !== 32'h100) begin n_err++; $display("FAIL align_addr got %h want 00000100", imem_addr); end
    endtask
`endif

    task automatic test_reset_midwait();
        bit ok;
        if_ready = 1'b1; rv_en = 1'b0; gnt_pct = 100;
        wait_for(0, ok);
        tick();
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (pc !== 32'h0 || imem_req !== 1'b0 || if_valid !== 1'b0) begin
            n_err++; $display("FAIL mid_rst got pc=%h req=%b v=%b want 0/0/0", pc, imem_req, if_valid); end
        outst = 1'b0; force_stale = 1'b1; gnt_pct = 0;
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0; imem_gnt = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        n_cmp++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_err++; $display("FAIL stale_ignore got v=%b req=%b addr=%h want 0/1/0", if_valid, imem_req, imem_addr); end
        force_stale = 1'b0; rv_en = 1'b1; gnt_pct = 100;
        imem_rvalid = 1'b0; imem_gnt = 1'b1;
        wait_for(1, ok);
        n_cmp++; if (!ok || if_pc !== 32'h0 || if_instr !== word_of(32'h0)) begin
            n_err++; $display("FAIL stale_first got pc=%h i=%h want 0/%h", if_pc, if_instr, word_of(32'h0)); end
    endtask

    function automatic logic [31:0] rand_tgt();
        logic [31:0] t;
        case ($urandom_range(3, 0))
            0:       t = $urandom;
            1:       t = 32'hFFFF_FFF0 | ($urandom_range(3, 0) << 2);
            2:       t = 32'h100 + $urandom_range(63, 0);
            default: t = $urandom & 32'h0000_0FFF;
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        t = t & ~32'h3;
`endif
        return t;
    endfunction

    task automatic test_random();
        logic [31:0] exp_pc, t, r_addr, o_instr, o_pc;
        bit          redir, acc, stall, pend;
        int          r, n_acc;
        rst_n = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_pc = 32'h0; n_acc = 0;
        gnt_pct = 60; rv_dly_max = 3; rv_en = 1'b1;
        for (int it = 0; it < 3000; it++) begin
            if_ready = ($urandom_range(99, 0) < 60);
            r = $urandom_range(99, 0);
            jump = (r < 6); branch_taken = (r >= 3 && r < 12);
            jump_target = rand_tgt(); branch_target = rand_tgt();
            redir = jump || branch_taken;
            t = jump ? jump_target : branch_target;
            acc = if_valid && if_ready; stall = if_valid && !if_ready;
            pend = imem_req && !imem_gnt;
            r_addr = imem_addr; o_instr = if_instr; o_pc = if_pc;
            tick();
            if (redir) exp_pc = t & ~32'h3;
            else if (acc) begin exp_pc = exp_pc + 32'd4; n_acc++; end
            n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL rnd_pc it=%0d got %h want %h", it, pc, exp_pc); end
            if (redir) begin
                n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rnd_redir_valid it=%0d got %b want 0", it, if_valid); end
            end else if (stall) begin
                n_cmp++; if (if_valid !== 1'b1 || if_instr !== o_instr || if_pc !== o_pc) begin
                    n_err++; $display("FAIL rnd_stall it=%0d got v=%b i=%h p=%h want 1/%h/%h", it, if_valid, if_instr, if_pc, o_instr, o_pc); end
            end else if (pend) begin
                n_cmp++; if (imem_req !== 1'b1 || imem_addr !== r_addr) begin
                    n_err++; $display("FAIL rnd_req_hold it=%0d got req=%b a=%h want 1/%h", it, imem_req, imem_addr, r_addr); end
            end
            if (imem_req) begin
                n_cmp++; if (imem_addr !== exp_pc) begin n_err++; $display("FAIL rnd_addr it=%0d got %h want %h", it, imem_addr, exp_pc); end
            end
            if (if_valid) begin
                n_cmp++; if (if_pc !== exp_pc || if_instr !== word_of(exp_pc)) begin
                    n_err++; $display("FAIL rnd_buf it=%0d got p=%h i=%h want %h/%h", it, if_pc, if_instr, exp_pc, word_of(exp_pc)); end
            end
        end
        jump = 1'b0; branch_taken = 1'b0;
        n_cmp++; if (n_acc < 50) begin n_err++; $display("FAIL rnd_progress got %0d accepts want >=50", n_acc); end
    endtask

    initial begin
        rst_n = 1'b0; jump = 1'b0; branch_taken = 1'b0; if_ready = 1'b0;
        jump_target = 32'h0; branch_target = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        test_reset();
        test_sequential();
        test_hold_stall();
        test_squash();
        test_priority();
        test_wrap();
`ifdef FETCH_MISALIGN_TRAP_EN
        test_fault();
`else
        test_align();
`endif
        test_reset_midwait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
